// File: rtl/pcm_stream_scheduler.sv
// Frames buffered PCM samples as {sync|seq, MSB, LSB} byte triplets for a byte-wide UART,
// and interleaves single-byte status frames that report dropped samples.
module pcm_stream_scheduler #(
    parameter int         FIFO_DEPTH  = 4,
    parameter logic [3:0] SYNC_NIBBLE = 4'hA,
    parameter logic [3:0] STAT_NIBBLE = 4'h5
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          enable,
    input  logic [15:0]                   pcm_in,
    input  logic                          pcm_valid,
    input  logic                          status_req,
    output logic [7:0]                    tx_data,
    output logic                          tx_valid,
    input  logic                          tx_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    output logic                          busy
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [2:0] {IDLE, HDR, MSB, LSB, STAT} state_t;

    state_t          state;
    logic [15:0]     mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [15:0]     shadow;
    logic [3:0]      seq;
    logic [3:0]      drop_cnt;
    logic            status_pending;

    logic            full;
    logic            empty;
    logic            accept;
    logic            pop;
    logic            push;
    logic            drop;
    logic            stat_done;

    function automatic logic [3:0] sat_inc4(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

    // A pop frees a slot in the same cycle, so a push at full is still accepted then.
    always_comb begin
        full      = (fifo_level == LW'(FIFO_DEPTH));
        empty     = (fifo_level == '0);
        accept    = tx_valid && tx_ready;
        pop       = (state == IDLE) && !status_pending && !empty;
        drop      = pcm_valid && enable && full && !pop;
        push      = pcm_valid && enable && (!full || pop);
        stat_done = accept && (state == STAT);
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= pcm_in;
        if (pop)  shadow <= mem[rd_ptr];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            fifo_level     <= '0;
            drop_cnt       <= '0;
            overflow       <= 1'b0;
            status_pending <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            fifo_level <= fifo_level + {{(LW-1){1'b0}}, push} - {{(LW-1){1'b0}}, pop};

            if (stat_done) begin
                drop_cnt <= {3'b000, drop};
                overflow <= drop;
            end else if (drop) begin
                drop_cnt <= sat_inc4(drop_cnt);
                overflow <= 1'b1;
            end

            if (stat_done)       status_pending <= 1'b0;
            else if (status_req) status_pending <= 1'b1;
        end
    end

    // Status frames are only launched from IDLE so a sample triplet is never split.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            tx_data  <= '0;
            tx_valid <= 1'b0;
            busy     <= 1'b0;
            seq      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (status_pending) begin
                        state    <= STAT;
                        tx_data  <= {STAT_NIBBLE, drop_cnt};
                        tx_valid <= 1'b1;
                        busy     <= 1'b1;
                    end else if (!empty) begin
                        state    <= HDR;
                        tx_data  <= {SYNC_NIBBLE, seq};
                        tx_valid <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                HDR: begin
                    if (accept) begin
                        state   <= MSB;
                        tx_data <= shadow[15:8];
                    end
                end
                MSB: begin
                    if (accept) begin
                        state   <= LSB;
                        tx_data <= shadow[7:0];
                    end
                end
                LSB: begin
                    if (accept) begin
                        state    <= IDLE;
                        tx_valid <= 1'b0;
                        busy     <= 1'b0;
                        seq      <= seq + 4'd1;
                    end
                end
                STAT: begin
                    if (accept) begin
                        state    <= IDLE;
                        tx_valid <= 1'b0;
                        busy     <= 1'b0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    tx_valid <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end
endmodule
